// File: rtl/diff_sign_mag_stage.sv
// Registered stage after an n-bit subtractor: converts the (n+1)-bit borrow-extended
// difference to sign-magnitude and hands results out through a 2-entry valid/ready buffer.
module diff_sign_mag_stage #(
    parameter int n     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [n:0]       in_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [n-1:0]     out_mag,
    output logic             out_neg,
    output logic             out_zero,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] neg_cnt
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    // Entry layout: {mag, neg, zero}
    function automatic logic [n+1:0] to_sign_mag(input logic [n:0] s);
        logic signed [n:0] s_sgn;
        logic signed [n:0] s_neg;
        logic [n-1:0]      mag;
        logic              neg;
        logic              zero;
        s_sgn = s;
        s_neg = -s_sgn;
        neg   = s[n];
        zero  = (s == '0);
        if (!neg)
            mag = s[n-1:0];
        else if (s[n-1:0] == '0)
            mag = '1;  // -2^n has no n-bit magnitude; clamp to the largest one
        else
            mag = s_neg[n-1:0];
        return {mag, neg, zero};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    state_t             state_q, state_d;
    logic               rdy_q, rdy_d;
    logic [n+1:0]       head_q, head_d;
    logic [n+1:0]       tail_q, tail_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [n+1:0]       conv;
    logic               push;
    logic               pop;

    assign conv = to_sign_mag(in_s);
    assign push = in_valid & rdy_q;
    assign pop  = (state_q != EMPTY) & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = conv;
                    state_d = ONE;
                end
            end
            ONE: begin
                case ({push, pop})
                    2'b10: begin
                        tail_d  = conv;
                        state_d = TWO;
                    end
                    2'b01: state_d = EMPTY;
                    2'b11: head_d = conv;
                    default: ;
                endcase
            end
            TWO: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Ready looks one cycle ahead so it never depends combinationally on out_ready
    assign rdy_d = (state_d != TWO);

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr)
            cnt_d = '0;
        else if (push && in_s[n])
            cnt_d = sat_inc(cnt_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            rdy_q   <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = (state_q != EMPTY);
    assign out_mag   = head_q[n+1:2];
    assign out_neg   = head_q[1];
    assign out_zero  = head_q[0];
    assign neg_cnt   = cnt_q;

endmodule

// File: tb/tb_diff_sign_mag_stage.sv
// Directed bench for diff_sign_mag_stage (n = 4, CNT_W = 2) with a queue-based reference model.
module tb_diff_sign_mag_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_s;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_mag;
    logic       out_neg;
    logic       out_zero;
    logic       cnt_clr;
    logic [1:0] neg_cnt;

    int checks = 0;
    int errors = 0;

    diff_sign_mag_stage #(.n(4), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_s(in_s),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mag(out_mag), .out_neg(out_neg), .out_zero(out_zero),
        .cnt_clr(cnt_clr), .neg_cnt(neg_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected entries as {mag[3:0], neg, zero}
    logic [5:0] mq[$];
    int         mcnt = 0;
    bit         mrdy = 0;

    function automatic logic [5:0] model_conv(input logic [4:0] s);
        int v;
        int m;
        v = s[4] ? int'(s) - 32 : int'(s);
        m = (v < 0) ? -v : v;
        if (m > 15) m = 15;
        return {m[3:0], v < 0, v == 0};
    endfunction

    always @(negedge rst_n) begin
        mq.delete();
        mcnt = 0;
        mrdy = 0;
    end

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            bit push, pop;
            push = in_valid && mrdy;
            pop  = (mq.size() > 0) && out_ready;
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(model_conv(in_s));
            if (cnt_clr) mcnt = 0;
            else if (push && in_s[4] && mcnt < 3) mcnt++;
            mrdy = (mq.size() < 2);
        end
    end

    always @(negedge clk) begin
        chk("cmp_in_ready", int'(in_ready), int'(mrdy));
        chk("cmp_out_valid", int'(out_valid), int'(mq.size() > 0));
        chk("cmp_neg_cnt", int'(neg_cnt), mcnt);
        if (mq.size() > 0) begin
            chk("cmp_mag", int'(out_mag), int'(mq[0][5:2]));
            chk("cmp_neg", int'(out_neg), int'(mq[0][1]));
            chk("cmp_zero", int'(out_zero), int'(mq[0][0]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string name, input int mag, input int neg, input int zero);
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_mag"}, int'(out_mag), mag);
        chk({name, "_neg"}, int'(out_neg), neg);
        chk({name, "_zero"}, int'(out_zero), zero);
    endtask

    logic [4:0] stream [10] = '{5'd1, 5'd2, 5'd31, 5'd4, 5'd20, 5'd15, 5'd0, 5'd17, 5'd8, 5'd30};

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_s = '0; out_ready = 1'b0; cnt_clr = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_neg_cnt", int'(neg_cnt), 0);
        chk("rst_out_mag", int'(out_mag), 0);
        step(); step();
        rst_n = 1'b1;
        chk("ready_before_edge", int'(in_ready), 0);
        step();
        chk("ready_after_release", int'(in_ready), 1);

        // Positive difference 9 - 3
        out_ready = 1'b1;
        in_valid = 1'b1; in_s = 5'b0_0110;
        step();
        in_valid = 1'b0;
        chk_head("pos6", 6, 0, 0);
        chk("pos6_cnt", int'(neg_cnt), 0);
        step();

        // Negative 3 - 9 then zero
        in_valid = 1'b1; in_s = 5'b1_1010;
        step();
        chk_head("neg6", 6, 1, 0);
        chk("neg6_cnt", int'(neg_cnt), 1);
        in_s = 5'b0_0000;
        step();
        in_valid = 1'b0;
        chk_head("zero", 0, 0, 1);
        chk("zero_cnt", int'(neg_cnt), 1);
        step();
        chk("drained", int'(out_valid), 0);

        // Backpressure: 3, -2, 7 with the consumer stalled
        out_ready = 1'b0;
        in_valid = 1'b1; in_s = 5'd3;
        step();
        chk("bp_ready1", int'(in_ready), 1);
        in_s = 5'b1_1110;
        step();
        chk("bp_ready2", int'(in_ready), 0);
        in_s = 5'd7;
        step(); step();
        chk_head("bp_hold3", 3, 0, 0);
        chk("bp_cnt", int'(neg_cnt), 2);
        out_ready = 1'b1;
        step();
        chk_head("bp_out2", 2, 1, 0);
        step();
        in_valid = 1'b0;
        chk_head("bp_out7", 7, 0, 0);
        step();
        chk("bp_empty", int'(out_valid), 0);

        // Streaming with simultaneous push/pop
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_s = stream[i];
            step();
            chk("stream_ready", int'(in_ready), 1);
        end
        in_valid = 1'b0;
        chk_head("stream_last", 2, 1, 0);
        step();

        // Counter saturation, clear priority, out-of-range word
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clr_cnt", int'(neg_cnt), 0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_s = 5'b1_1111 - 5'(i);
            step();
        end
        chk("sat_cnt", int'(neg_cnt), 3);
        cnt_clr = 1'b1; in_s = 5'b1_1000;
        step();
        cnt_clr = 1'b0;
        chk("clr_prio_cnt", int'(neg_cnt), 0);
        in_s = 5'b1_0000;
        step();
        in_valid = 1'b0;
        chk_head("oor", 15, 1, 0);
        chk("oor_cnt", int'(neg_cnt), 1);
        step();

        // Asynchronous reset while full
        out_ready = 1'b0;
        in_valid = 1'b1; in_s = 5'b1_1011;
        step();
        in_s = 5'd6;
        step();
        in_valid = 1'b0;
        chk("full_ready", int'(in_ready), 0);
        chk("full_valid", int'(out_valid), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_cnt", int'(neg_cnt), 0);
        chk("mid_rst_ready", int'(in_ready), 0);
        chk("mid_rst_mag", int'(out_mag), 0);
        #1 rst_n = 1'b1;
        step();
        chk("post_rst_ready", int'(in_ready), 1);
        out_ready = 1'b1;
        in_valid = 1'b1; in_s = 5'd9;
        step();
        in_valid = 1'b0;
        chk_head("post_rst_first", 9, 0, 0);
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
